// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity modes.
// Also used by the transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-word handshake bundle between the UART receiver and its consumer.
// The receiver uses the master modport and the consumer uses the slave modport.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_error;
    logic                 framing_error;
    logic                 overrun_error;
    logic                 rx_busy;

    modport master (
        output data_out,
        output data_valid,
        output parity_error,
        output framing_error,
        output overrun_error,
        output rx_busy,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  framing_error,
        input  overrun_error,
        input  rx_busy,
        output data_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter with a restartable phase.
// It strobes at mid start bit (half) or once per full bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_half,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == (i_half ? MID : LAST));

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start-bit validation, LSB-first deserialiser,
// parity and stop checks, and a single-entry output word with error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_core_if.master bus
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic r_rx_s1;
    logic r_rx_s2;
    uart_rx_state_t r_state;
    uart_rx_state_t w_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic [BW-1:0] r_bit_cnt;
    logic r_par_err;
    logic r_frm_err;
    logic r_load;
    logic r_valid;
    logic r_perr;
    logic r_ferr;
    logic r_oerr;
    logic w_tick;
    logic w_restart;
    logic w_half;
    logic w_go;
    logic w_data_go;
    logic w_shift_en;
    logic w_par_en;
    logic w_stop_en;
    logic w_par_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_restart(w_restart),
        .i_half   (w_half),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_restart  = 1'b0;
        w_half     = 1'b0;
        w_go       = 1'b0;
        w_data_go  = 1'b0;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_stop_en  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_restart = 1'b1;
                if (!r_rx_s2) begin
                    w_next = ST_START;
                    w_go   = 1'b1;
                end
            end
            ST_START: begin
                w_half = 1'b1;
                if (w_tick) begin
                    if (r_rx_s2) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next    = ST_DATA;
                        w_restart = 1'b1;
                        w_data_go = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_par_en = 1'b1;
                    w_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_stop_en = 1'b1;
                    w_next    = r_rx_s2 ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                w_restart = 1'b1;
                if (r_rx_s2) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_par_calc = (^r_shift) ^ r_rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_load <= w_stop_en;
            if (w_go) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end
            if (w_data_go) begin
                r_bit_cnt <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_par_en) begin
                r_par_err <= (PARITY_MODE == PARITY_ODD) ? ~w_par_calc : w_par_calc;
            end
            if (w_stop_en) begin
                r_frm_err <= ~r_rx_s2;
            end
        end
    end

    // A same-cycle accept frees the slot, so the new word loads cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_oerr     <= 1'b0;
        end else if (r_load && (!r_valid || bus.data_ready)) begin
            r_data_out <= r_shift;
            r_valid    <= 1'b1;
            r_perr     <= r_par_err;
            r_ferr     <= r_frm_err;
            r_oerr     <= 1'b0;
        end else if (r_load) begin
            r_oerr <= 1'b1;
        end else if (r_valid && bus.data_ready) begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.data_valid    = r_valid;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;
    assign bus.overrun_error = r_oerr;
    assign bus.rx_busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Stand-alone UART receiver, the receive-side counterpart of the team's UART transmitter.
- Oversamples the asynchronous serial line and validates the start bit.
- Deserialises LSB-first data, checks optional parity and the stop bit, then presents each word on a valid/ready handshake with per-word error flags.
- Sits between the pad-level rx pin and the host/register interface.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 4 and even.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx  input  1  asynchronous serial line, idle high
- data_out  output  DATA_BITS  received word, LSB = first bit on the line
- data_valid  output  1  data_out and the error flags are valid
- data_ready  input  1  consumer accepts the word when data_valid && data_ready
- parity_error  output  1  held word failed the parity check
- framing_error  output  1  held word had stop bit = 0
- overrun_error  output  1  at least one frame was lost while data_valid was pending
- rx_busy  output  1  FSM is not in IDLE

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high.
  - Reset values: data_out = 0, all flags = 0, data_valid = 0, rx_busy = 0, FSM = IDLE, counters = 0, synchroniser flops = 1.
- Synchroniser: rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on rx_s = 0, go to START and clear the bit-period counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), resample. If rx_s = 1 (glitch), return to IDLE with no output. If rx_s = 0, go to DATA and clear the counter.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) into a shift register, LSB first. After DATA_BITS samples go to PARITY if PARITY_MODE != 0, else go to STOP.
  - PARITY: sample one bit.
    - Even mode: error if the XOR of data bits and the parity bit = 1.
    - Odd mode: error if that XOR = 0.
  - STOP: sample one bit. If 1, go to IDLE. If 0, set the framing error and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. A break condition therefore produces exactly one word.
- Output loading: in the cycle after the stop-bit sample, the word is loaded into data_out.
  - If data_valid = 0: load data_out, parity_error and framing_error; set data_valid = 1.
  - If data_valid = 1 (not yet consumed): discard the new word, keep the held word, set overrun_error = 1.
  - If data_ready is asserted in the same cycle as the load, the held word is consumed and the new word is loaded (no overrun).
- Handshake:
  - data_valid stays high, and data_out and the flags stay stable, until data_valid && data_ready.
  - On acceptance, data_valid, parity_error, framing_error and overrun_error clear on the next edge, unless a new word loads in that same edge.
- Latency: the word appears 2 + CLKS_PER_BIT/2 + CLKS_PER_BIT*(DATA_BITS + P + 1) + 1 cycles after rx falls (P = 1 if parity is enabled), with ±1 cycle of synchroniser phase.
- Counter: the bit-period counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1. The bit counter is $clog2(DATA_BITS+1) bits wide.
- Reset mid-frame: abandons the frame. No word and no flags are produced; after release the receiver waits for a fresh falling edge.
- rx_busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef uart_rx_state_t;
  - the parity mode constants PARITY_NONE, PARITY_EVEN, PARITY_ODD, shared with the transmitter.
- One natural sub-module: uart_baud_tick. It is a counter with a restartable phase that outputs a mid-bit sample strobe.

Test Plan:
- Framed 8N1 word (CLKS_PER_BIT=16, PARITY_MODE=0): drive 0xA5, data_ready=1 -> data_out=0xA5, data_valid high for 1 cycle, 155±1 cycles after rx falls, all flags 0.
- Parity check (PARITY_MODE=1): send 0x0F with parity bit 0 -> parity_error=0. Then 0x0F with parity bit 1 -> parity_error=1 with data_out=0x0F.
- Break and framing error: hold rx low for 30 bit times -> exactly one word 0x00 with framing_error=1, rx_busy high until rx returns high, no second word.
- Start-bit glitch: rx low for 4 cycles then high -> no data_valid, FSM back to IDLE, rx_busy low within CLKS_PER_BIT/2+3 cycles.
- Overrun: data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11 with overrun_error=1. Assert data_ready for one cycle -> data_valid and all flags clear next cycle.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 -> all outputs are their reset values. A following 0x3C frame is received correctly with no flags.
